muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the decoded M-extension operation (funct3) and two register operands from the execute stage, and returns a 32-bit result with a start/busy/done handshake.
- The core stalls its pipeline while busy is high.
- Sits beside the main ALU in the datapath, selected by the control decode when funct7 = 0000001.

Parameters:
- XLEN, 32, operand/result width. Only 32 is verified; iteration count equals XLEN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled at rising clk edge; accepted only when busy=0
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 operand (multiplicand / dividend)
- op_b  input  XLEN  rs2 operand (multiplier / divisor)
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when result becomes valid
- result  output  XLEN  registered result; held until the next completion or reset

Behaviour:
- Design: one clock; reset is asynchronous and active-high. On rst, state is IDLE and busy=0, done=0, result=0, with all internal registers cleared.
- FSM states are IDLE, CALC and FINISH. busy = (state != IDLE).
- IDLE:
  - On start=1, latch funct3 and the operand magnitudes and sign flags, clear the 5-bit counter and go to CALC.
  - Signed operands: op_a is signed for MULH, MULHSU, DIV and REM; op_b is signed for MULH, DIV and REM. Magnitude = two's-complement absolute value (0x80000000 stays 0x80000000 as unsigned).
- CALC, one iteration per clock, 32 iterations (counter 0..31); at counter=31, go to FINISH.
  - Multiply: shift-add on magnitudes into a 64-bit product register.
  - Divide: restoring division on magnitudes with a 32-bit quotient and a 33-bit partial remainder.
- FINISH, one cycle:
  - Apply sign correction and select the result.
  - At the next edge, load result, set done=1 and return to IDLE.
  - done clears at the following edge.
- Latency: start sampled at edge E0; done and result are valid in the cycle after edge E33. The latency is fixed at 33 cycles for all ops, including special cases.
- Result selection:
  - MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32].
  - The 64-bit product is negated when the operand signs differ; only signed operands contribute a sign.
- DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Divide by zero (op_b=0), no trap: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a unchanged.
- Signed overflow (DIV with op_a=0x80000000 and op_b=0xFFFFFFFF): quotient = 0x80000000, REM = 0.
- start while busy=1 is ignored. It is not queued, and the in-flight operands and op are unaffected.
- start sampled in the same cycle that done=1 (state IDLE) is accepted; back-to-back operations therefore have a 34-cycle throughput.
- Operands and funct3 need only be valid on the start edge; later changes have no effect.
- rst asserted mid-operation aborts immediately: IDLE, busy=0, no done pulse, result=0.

Test Plan:
- MUL: op_a=7, op_b=0xFFFFFFFD -> result=0xFFFFFFEB. busy rises after the start edge; done pulses exactly 33 cycles after the start edge, for 1 cycle.
- High-half multiplies with 0x80000000 x 0x80000000 and 0xFFFFFFFF x 0xFFFFFFFF:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- Signed division, op_a=0xFFFFFFF9 (-7), op_b=2: DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. With DIVU: 0x7FFFFFFC.
- Special cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
  - DIVU 123 / 0 -> 0xFFFFFFFF; REMU 123 / 0 -> 123; DIV -5 / 0 -> 0xFFFFFFFF.
- Start while busy: issue MUL 3 x 4, then at cycle 10 issue DIV 9 / 3 -> only one done pulse, result=12, at cycle 33. Start asserted during the done cycle is accepted, and its done follows 33 cycles later.
- Reset mid-op: start DIVU 100 / 7, assert rst at cycle 15 -> busy=0, done=0 and result=0 immediately and asynchronously, with no done pulse afterwards. A fresh start after reset release completes normally (100 / 7 -> 14).

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, XLEN iterations, with sign correction in a final cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  // Handshake: start is taken on a rising edge only while busy=0; done is a
  // one-cycle pulse with result valid in that same cycle and held afterwards.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  ONE      = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE2    = (2*XLEN)'(1);

  state_t              r_state;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_a_mag;
  logic [XLEN-1:0]     r_b_mag;
  logic                r_a_neg;
  logic                r_b_neg;
  logic                r_b_zero;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_prod;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_result;
  logic                r_done;

  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic [XLEN:0]       w_mul_add;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_prod_next;
  logic [XLEN:0]       w_div_shift;
  logic [XLEN-1:0]     w_div_diff;
  logic                w_div_ge;
  logic                w_res_neg;
  logic [2*XLEN-1:0]   w_prod_signed;
  logic [XLEN-1:0]     w_quo_signed;
  logic [XLEN-1:0]     w_rem_signed;
  logic [XLEN-1:0]     w_final;

  assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                      (funct3 == 3'b110);
  assign w_a_neg    = w_a_signed & op_a[XLEN-1];
  assign w_b_neg    = w_b_signed & op_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~op_a + ONE) : op_a;
  assign w_b_mag    = w_b_neg ? (~op_b + ONE) : op_b;

  // Multiplier sits in the low half and is consumed LSB-first as the sum shifts in.
  assign w_mul_add   = r_prod[0] ? {1'b0, r_a_mag} : '0;
  assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + w_mul_add;
  assign w_prod_next = {w_mul_sum, r_prod[XLEN-1:1]};

  // w_div_shift is the 33-bit partial remainder; after a subtract it always fits XLEN bits.
  assign w_div_shift = {r_rem, r_quo[XLEN-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b_mag});
  assign w_div_diff  = w_div_shift[XLEN-1:0] - r_b_mag;

  assign w_res_neg     = r_a_neg ^ r_b_neg;
  assign w_prod_signed = w_res_neg ? (~r_prod + ONE2) : r_prod;
  assign w_quo_signed  = r_b_zero  ? '1 : (w_res_neg ? (~r_quo + ONE) : r_quo);
  assign w_rem_signed  = r_a_neg   ? (~r_rem + ONE) : r_rem;

  always_comb begin
    w_final = '0;
    case (r_op)
      3'b000:                 w_final = w_prod_signed[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_signed[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo_signed;
      default:                w_final = w_rem_signed;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a_mag  <= '0;
      r_b_mag  <= '0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_b_zero <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= funct3;
            r_a_mag  <= w_a_mag;
            r_b_mag  <= w_b_mag;
            r_a_neg  <= w_a_neg;
            r_b_neg  <= w_b_neg;
            r_b_zero <= (op_b == '0);
            r_cnt    <= '0;
            r_prod   <= {{XLEN{1'b0}}, w_b_mag};
            r_quo    <= w_a_mag;
            r_rem    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_prod <= w_prod_next;
          r_quo  <= {r_quo[XLEN-2:0], w_div_ge};
          r_rem  <= w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
          if (r_cnt == CNT_LAST) begin
            r_state <= S_FINISH;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_FINISH: begin
          r_result <= w_final;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized operations
// compared against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Presents an op so it is sampled at the next rising edge, then scrambles inputs.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic busy_seen);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    funct3    = 3'($urandom);
    op_a      = $urandom;
    op_b      = $urandom;
    busy_seen = busy;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output logic busy_seen);
    @(negedge clk);
    start_op(f, a, b, busy_seen);
    wait_done(lat);
    res = result;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    funct3 = '0;
    op_a   = '0;
    op_b   = '0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] res;
    int lat;
    logic bs;
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, res, lat, bs);
    checks++; if (bs !== 1'b1) begin errors++; $display("FAIL mul_busy_rise: got %b want 1", bs); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", lat); end
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", res); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_width: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_idle_after: got %b want 0", busy); end
  endtask

  task automatic test_mul_high();
    logic [2:0]  f_t[3]   = '{3'b001, 3'b010, 3'b011};
    logic [31:0] a_t[3]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp_t[3] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] res;
    int lat;
    logic bs;
    for (int i = 0; i < 3; i++) begin
      do_op(f_t[i], a_t[i], a_t[i], res, lat, bs);
      checks++; if (res !== exp_t[i]) begin errors++; $display("FAIL mul_high_%0d: got %h want %h", i, res, exp_t[i]); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL mul_high_lat_%0d: got %0d want 33", i, lat); end
    end
  endtask

  task automatic test_div_signed();
    logic [2:0]  f_t[3]   = '{3'b100, 3'b110, 3'b101};
    logic [31:0] exp_t[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
    logic [31:0] res;
    int lat;
    logic bs;
    for (int i = 0; i < 3; i++) begin
      do_op(f_t[i], 32'hFFFF_FFF9, 32'd2, res, lat, bs);
      checks++; if (res !== exp_t[i]) begin errors++; $display("FAIL div_signed_%0d: got %h want %h", i, res, exp_t[i]); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f_t[5]   = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100};
    logic [31:0] a_t[5]   = '{32'h8000_0000, 32'h8000_0000, 32'd123, 32'd123, 32'hFFFF_FFFB};
    logic [31:0] b_t[5]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    logic [31:0] exp_t[5] = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd123, 32'hFFFF_FFFF};
    logic [31:0] res;
    int lat;
    logic bs;
    for (int i = 0; i < 5; i++) begin
      do_op(f_t[i], a_t[i], b_t[i], res, lat, bs);
      checks++; if (res !== exp_t[i]) begin errors++; $display("FAIL special_%0d: got %h want %h", i, res, exp_t[i]); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL special_lat_%0d: got %0d want 33", i, lat); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] res = '0;
    int pulses = 0;
    int first_lat = 0;
    logic bs;
    @(negedge clk);
    start_op(3'b000, 32'd3, 32'd4, bs);
    for (int cyc = 1; cyc <= 75; cyc++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          first_lat = cyc;
          res = result;
        end
      end
      if (cyc == 10) begin
        start = 1'b1; funct3 = 3'b100; op_a = 32'd9; op_b = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_start_pulses: got %0d want 1", pulses); end
    checks++; if (first_lat !== 33) begin errors++; $display("FAIL busy_start_latency: got %0d want 33", first_lat); end
    checks++; if (res !== 32'd12) begin errors++; $display("FAIL busy_start_result: got %h want 0000000c", res); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat;
    logic bs;
    do_op(3'b000, 32'd5, 32'd6, res, lat, bs);
    checks++; if (res !== 32'd30) begin errors++; $display("FAIL b2b_first: got %h want 0000001e", res); end
    // Still inside the done cycle: issue the next op immediately.
    start_op(3'b101, 32'd100, 32'd9, bs);
    checks++; if (bs !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b want 1", bs); end
    wait_done(lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    checks++; if (result !== 32'd11) begin errors++; $display("FAIL b2b_second: got %h want 0000000b", result); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int lat;
    int pulses = 0;
    int busy_hi = 0;
    logic bs;
    @(negedge clk);
    start_op(3'b101, 32'd100, 32'd7, bs);
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h want 0", result); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
      if (busy === 1'b1) busy_hi++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", pulses); end
    checks++; if (busy_hi !== 0) begin errors++; $display("FAIL midrst_stay_idle: busy cycles %0d want 0", busy_hi); end
    do_op(3'b101, 32'd100, 32'd7, res, lat, bs);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL midrst_restart: got %h want 0000000e", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL midrst_restart_lat: got %0d want 33", lat); end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, res, exp_v;
    int lat;
    logic bs;
    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp_q.push_back(ref_model(f, a, b));
      do_op(f, a, b, res, lat, bs);
      exp_v = exp_q.pop_front();
      checks++;
      if (res !== exp_v) begin
        errors++;
        $display("FAIL random_%0d f3=%0d a=%h b=%h: got %h want %h", i, f, a, b, res, exp_v);
      end
      checks++; if (lat !== 33) begin errors++; $display("FAIL random_lat_%0d: got %0d want 33", i, lat); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div_signed();
    test_special();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
